// File: rtl/routine_sequencer.sv
// routine_sequencer: drives the step clock and run/hold line for the light
// routines, picks one routine's 46-bit bus via a debounced key or an
// auto-advance timer, and registers it onto the board LEDs and 7-segment pins.
// Every switch blanks the board and holds the routines in reset for a few steps.
module routine_sequencer #(
  parameter int TICK_DIV        = 12500000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int AUTO_STEPS      = 64,
  parameter int BLANK_STEPS     = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        NextKey,
  input  logic        AutoEn,
  input  logic [45:0] Bus0,
  input  logic [45:0] Bus1,
  input  logic [45:0] Bus2,
  input  logic [45:0] Bus3,
  output logic        StepClock,
  output logic        RoutineRun,
  output logic [9:0]  LedRed,
  output logic [7:0]  LedGrn,
  output logic [27:0] Hex,
  output logic [1:0]  Selected
);

  localparam int DIV_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int STEP_W = (AUTO_STEPS > 1) ? $clog2(AUTO_STEPS) : 1;
  localparam int BLK_W  = (BLANK_STEPS > 1) ? $clog2(BLANK_STEPS) : 1;

  // LEDs dark, 7-segment segments all off (active-low).
  localparam logic [45:0] BLANK_BUS = {18'd0, {28{1'b1}}};

  typedef enum logic {
    S_BLANK = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  // Synchronizers
  logic key_s1_q, key_s1_d, key_s2_q, key_s2_d;
  logic auto_s1_q, auto_s1_d, auto_s2_q, auto_s2_d;

  // Debounce
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             key_lvl_q, key_lvl_d;
  logic             press;

  // Divider
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             step_clk_q, step_clk_d;
  logic             tick_q, tick_d;

  // Sequencer
  state_t            state_q, state_d;
  logic [1:0]        sel_q, sel_d;
  logic [BLK_W-1:0]  blank_cnt_q, blank_cnt_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic [45:0]       out_q, out_d;
  logic [45:0]       bus_sel;
  logic              advance;

  // Next-state for the two-flop synchronizers on the raw key and switch.
  always_comb begin
    key_s1_d  = NextKey;
    key_s2_d  = key_s1_q;
    auto_s1_d = AutoEn;
    auto_s2_d = auto_s1_q;
  end

  // Debounce: accept a new key level only after it has been stable long enough;
  // a press is the accepted high-to-low transition.
  always_comb begin
    deb_cnt_d = '0;
    key_lvl_d = key_lvl_q;
    press     = 1'b0;
    if (key_s2_q != key_lvl_q) begin
      if (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
        key_lvl_d = key_s2_q;
        press     = ~key_s2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end
  end

  // Divider: StepClock is high for the first half of each period, and the tick
  // is registered so it lands on the same cycle as the StepClock rise.
  always_comb begin
    if (div_cnt_q == DIV_W'(TICK_DIV - 1)) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
    step_clk_d = (div_cnt_d < DIV_W'(TICK_DIV / 2));
    tick_d     = (div_cnt_q == DIV_W'(TICK_DIV - 1));
  end

  // Routine bus selected for display.
  always_comb begin
    case (sel_q)
      2'd0:    bus_sel = Bus0;
      2'd1:    bus_sel = Bus1;
      2'd2:    bus_sel = Bus2;
      default: bus_sel = Bus3;
    endcase
  end

  // Sequencer next-state: BLANK waits a fixed number of ticks, RUN shows the
  // selected bus until a press or the auto timer advances to the next routine.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    blank_cnt_d = blank_cnt_q;
    step_cnt_d  = step_cnt_q;
    out_d       = BLANK_BUS;
    advance     = 1'b0;
    case (state_q)
      S_BLANK: begin
        if (tick_q) begin
          if (blank_cnt_q == BLK_W'(BLANK_STEPS - 1)) begin
            blank_cnt_d = '0;
            state_d     = S_RUN;
          end else begin
            blank_cnt_d = blank_cnt_q + BLK_W'(1);
          end
        end
      end
      S_RUN: begin
        advance = press |
                  (auto_s2_q & tick_q & (step_cnt_q == STEP_W'(AUTO_STEPS - 1)));
        if (advance) begin
          sel_d      = sel_q + 2'd1;
          step_cnt_d = '0;
          state_d    = S_BLANK;
        end else begin
          out_d = bus_sel;
          // With auto-advance off the step count freezes where it is.
          if (tick_q && auto_s2_q) begin
            step_cnt_d = step_cnt_q + STEP_W'(1);
          end
        end
      end
      default: state_d = S_BLANK;
    endcase
  end

  // All state registers, cleared asynchronously.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      key_s1_q    <= 1'b1;
      key_s2_q    <= 1'b1;
      auto_s1_q   <= 1'b0;
      auto_s2_q   <= 1'b0;
      deb_cnt_q   <= '0;
      key_lvl_q   <= 1'b1;
      div_cnt_q   <= '0;
      step_clk_q  <= 1'b0;
      tick_q      <= 1'b0;
      state_q     <= S_BLANK;
      sel_q       <= 2'd0;
      blank_cnt_q <= '0;
      step_cnt_q  <= '0;
      out_q       <= BLANK_BUS;
    end else begin
      key_s1_q    <= key_s1_d;
      key_s2_q    <= key_s2_d;
      auto_s1_q   <= auto_s1_d;
      auto_s2_q   <= auto_s2_d;
      deb_cnt_q   <= deb_cnt_d;
      key_lvl_q   <= key_lvl_d;
      div_cnt_q   <= div_cnt_d;
      step_clk_q  <= step_clk_d;
      tick_q      <= tick_d;
      state_q     <= state_d;
      sel_q       <= sel_d;
      blank_cnt_q <= blank_cnt_d;
      step_cnt_q  <= step_cnt_d;
      out_q       <= out_d;
    end
  end

  assign StepClock             = step_clk_q;
  assign RoutineRun            = (state_q == S_RUN);
  assign Selected              = sel_q;
  assign {LedRed, LedGrn, Hex} = out_q;

endmodule

// File: tb/tb_routine_sequencer.sv
// Bench for routine_sequencer with small parameters; expected pin snapshots
// are queued per cycle and compared as the cycles elapse.
module tb_routine_sequencer;

  localparam logic [45:0] BLANK_PINS = {18'd0, 28'hFFFFFFF};

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        NextKey = 1'b1;
  logic        AutoEn = 1'b0;
  logic [45:0] Bus0, Bus1, Bus2, Bus3;
  logic        StepClock, RoutineRun;
  logic [9:0]  LedRed;
  logic [7:0]  LedGrn;
  logic [27:0] Hex;
  logic [1:0]  Selected;

  routine_sequencer #(
    .TICK_DIV(4), .DEBOUNCE_CYCLES(3), .AUTO_STEPS(5), .BLANK_STEPS(2)
  ) dut (
    .Clock(Clock), .Reset(Reset), .NextKey(NextKey), .AutoEn(AutoEn),
    .Bus0(Bus0), .Bus1(Bus1), .Bus2(Bus2), .Bus3(Bus3),
    .StepClock(StepClock), .RoutineRun(RoutineRun),
    .LedRed(LedRed), .LedGrn(LedGrn), .Hex(Hex), .Selected(Selected)
  );

  typedef struct {
    int          cyc;
    string       name;
    logic [49:0] snap;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc;
  logic [49:0] act;

  assign act = {Selected, RoutineRun, StepClock, LedRed, LedGrn, Hex};

  always #5 Clock = ~Clock;

  // Cycles since reset release; cyc == k means k rising edges have passed.
  always @(posedge Clock or posedge Reset) begin
    if (Reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  function automatic logic [49:0] mk(input logic [1:0] s, input logic r,
                                     input logic sc, input logic [45:0] pins);
    return {s, r, sc, pins};
  endfunction

  // StepClock: low right after reset, then 1,1,0,0 with rises on ticks (cyc%4==0).
  function automatic logic exp_sc(input int c);
    if (c == 0) return 1'b0;
    return ((c % 4) < 2);
  endfunction

  function automatic logic [45:0] bus_of(input int s);
    case (s % 4)
      0:       return Bus0;
      1:       return Bus1;
      2:       return Bus2;
      default: return Bus3;
    endcase
  endfunction

  task automatic push(input int c, input string nm, input logic [49:0] v);
    exp_t e;
    e.cyc  = c;
    e.name = nm;
    e.snap = v;
    sb.push_back(e);
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    #2 Reset = 1'b1;
    for (int i = 0; i < 3; i++) push(0, "reset_hold", mk(2'd0, 1'b0, 1'b0, BLANK_PINS));
    while (sb.size() > 0) begin
      @(posedge Clock); #1;
      e = sb.pop_front();
      n_cmp++;
      if (act !== e.snap) begin
        n_bad++;
        $display("FAIL %s got=%h expected=%h", e.name, act, e.snap);
      end
    end
  endtask

  task automatic test_power_on();
    exp_t e;
    Reset = 1'b0;
    for (int c = 1; c <= 12; c++)
      push(c, "power_on", mk(2'd0, c >= 9, exp_sc(c), (c >= 10) ? Bus0 : BLANK_PINS));
    while (sb.size() > 0) begin
      @(posedge Clock); #1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_cmp++;
        if (act !== e.snap) begin
          n_bad++;
          $display("FAIL %s cyc=%0d got=%h expected=%h", e.name, cyc, act, e.snap);
        end
      end
    end
  endtask

  task automatic test_press_debounce();
    exp_t e;
    int s, p, t1, t2, d;
    s  = cyc;
    // 2 sync + 3 stable cycles after the held-low level starts at s+4.
    p  = s + 8;
    t1 = ((p + 1 + 3) / 4) * 4;
    t2 = t1 + 4;
    for (int c = s + 1; c <= s + 24; c++)
      push(c, "press_debounce",
           mk((c <= p) ? 2'd0 : 2'd1, (c <= p) || (c >= t2 + 1), exp_sc(c),
              (c <= p) ? Bus0 : ((c >= t2 + 2) ? Bus1 : BLANK_PINS)));
    NextKey = 1'b0;
    while (sb.size() > 0) begin
      @(posedge Clock); #1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_cmp++;
        if (act !== e.snap) begin
          n_bad++;
          $display("FAIL %s cyc=%0d got=%h expected=%h", e.name, cyc, act, e.snap);
        end
      end
      d = cyc - s;
      if (d == 1 || d == 3 || d >= 14) NextKey = 1'b1;
      else                             NextKey = 1'b0;
    end
    NextKey = 1'b1;
  endtask

  task automatic test_press_in_blank();
    exp_t e;
    Reset = 1'b1;
    @(posedge Clock); #1;
    NextKey = 1'b0;
    @(posedge Clock); #1;
    Reset = 1'b0;
    for (int c = 1; c <= 24; c++)
      push(c, "press_in_blank", mk(2'd0, c >= 9, exp_sc(c), (c >= 10) ? Bus0 : BLANK_PINS));
    while (sb.size() > 0) begin
      @(posedge Clock); #1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_cmp++;
        if (act !== e.snap) begin
          n_bad++;
          $display("FAIL %s cyc=%0d got=%h expected=%h", e.name, cyc, act, e.snap);
        end
      end
      if (cyc >= 16) NextKey = 1'b1;
    end
    NextKey = 1'b1;
  endtask

  task automatic test_auto_advance();
    exp_t e;
    int m, k, r;
    AutoEn = 1'b1;
    pulse_reset();
    for (int c = 1; c <= 124; c++) begin
      if (c <= 8) begin
        push(c, "auto_advance", mk(2'd0, 1'b0, exp_sc(c), BLANK_PINS));
      end else begin
        // One RUN (20 cycles = 5 ticks) plus one BLANK (8 cycles = 2 ticks) per routine.
        m = c - 9;
        k = m / 28;
        r = m % 28;
        if (r <= 19)
          push(c, "auto_advance", mk(2'(k % 4), 1'b1, exp_sc(c),
                                     (r >= 1) ? bus_of(k) : BLANK_PINS));
        else
          push(c, "auto_advance", mk(2'((k + 1) % 4), 1'b0, exp_sc(c), BLANK_PINS));
      end
    end
    while (sb.size() > 0) begin
      @(posedge Clock); #1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_cmp++;
        if (act !== e.snap) begin
          n_bad++;
          $display("FAIL %s cyc=%0d got=%h expected=%h", e.name, cyc, act, e.snap);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    AutoEn = 1'b1;
    pulse_reset();
    push(70, "mid_run_before", mk(2'd2, 1'b1, exp_sc(70), Bus2));
    while (sb.size() > 0) begin
      @(posedge Clock); #1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_cmp++;
        if (act !== e.snap) begin
          n_bad++;
          $display("FAIL %s cyc=%0d got=%h expected=%h", e.name, cyc, act, e.snap);
        end
      end
    end
    // Assert reset between clock edges; outputs must clear without a clock.
    #3 Reset = 1'b1;
    push(0, "mid_run_async", mk(2'd0, 1'b0, 1'b0, BLANK_PINS));
    push(0, "mid_run_held", mk(2'd0, 1'b0, 1'b0, BLANK_PINS));
    #1;
    e = sb.pop_front();
    n_cmp++;
    if (act !== e.snap) begin
      n_bad++;
      $display("FAIL %s got=%h expected=%h", e.name, act, e.snap);
    end
    @(posedge Clock); #1;
    e = sb.pop_front();
    n_cmp++;
    if (act !== e.snap) begin
      n_bad++;
      $display("FAIL %s got=%h expected=%h", e.name, act, e.snap);
    end
    Reset  = 1'b0;
    AutoEn = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    Bus0 = 46'h2AAA_5555_1234;
    Bus1 = 46'h1555_0F0F_ABCD;
    Bus2 = 46'h0F0F_33CC_0001;
    Bus3 = 46'h3C3C_1248_8421;
    test_reset();
    test_power_on();
    test_press_debounce();
    test_press_in_blank();
    test_auto_advance();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
